// File: rtl/bubble_page_buffer_pkg.sv
// Shared encodings for the bubble page buffer: access types, channel modes, swap FSM, read-source select.
// Combinational helpers only; no latency and no flow control of their own.
package bubble_page_buffer_pkg;

    localparam logic [2:0] ACC_BOOT = 3'b110;
    localparam logic [2:0] ACC_USER = 3'b111;

    typedef enum logic [1:0] {
        CHM_1   = 2'b00,
        CHM_2   = 2'b01,
        CHM_4   = 2'b10,
        CHM_RSV = 2'b11
    } chmode_e;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } swap_state_e;

    typedef enum logic [1:0] {
        RSEL_EMPTY = 2'b00,
        RSEL_BOOT  = 2'b01,
        RSEL_USER  = 2'b10
    } rd_sel_e;

    // Reserved mode behaves as the 2-channel mode.
    function automatic logic [2:0] active_count(input chmode_e mode);
        case (mode)
            CHM_1:   return 3'd1;
            CHM_4:   return 3'd4;
            default: return 3'd2;
        endcase
    endfunction

    function automatic rd_sel_e decode_acctype(input logic [2:0] acc);
        if (acc == ACC_BOOT) begin
            return RSEL_BOOT;
        end else if (acc == ACC_USER) begin
            return RSEL_USER;
        end else begin
            return RSEL_EMPTY;
        end
    endfunction

endpackage

// File: rtl/bubble_channel_ram.sv
// One bubble output channel: 1-bit boot RAM, double-banked user RAM and the output read register.
// Read data valid one MCLK after an enabled edge; writes always accepted, no backpressure.
module bubble_channel_ram
    import bubble_page_buffer_pkg::*;
#(
    parameter int                       BOOT_AW   = 13,
    parameter int                       PAGE_AW   = 10,
    parameter logic [2**BOOT_AW-1:0]    BOOT_INIT = '0
) (
    input  logic                MCLK,
    input  logic                RESET,
    input  logic                wr_en,
    input  logic                wr_region,
    input  logic [BOOT_AW-1:0]  wr_line,
    input  logic                wr_bank,
    input  logic                wr_dat,
    input  logic                rd_en,
    input  rd_sel_e             rd_sel,
    input  logic [BOOT_AW-1:0]  rd_line,
    input  logic                rd_bank,
    output logic                rd_dat
);

    localparam int BOOT_DEPTH = 2**BOOT_AW;
    localparam int USER_DEPTH = 2**(PAGE_AW+1);

    // Boot image bit i holds line i; the preload image is the power-up content.
    logic [BOOT_DEPTH-1:0] boot_mem = BOOT_INIT;
    logic                  user_mem [USER_DEPTH];

    logic [PAGE_AW:0] user_wr_idx;
    logic [PAGE_AW:0] user_rd_idx;

    assign user_wr_idx = {wr_bank, wr_line[PAGE_AW-1:0]};
    assign user_rd_idx = {rd_bank, rd_line[PAGE_AW-1:0]};

    always_ff @(posedge MCLK) begin
        if (wr_en) begin
            if (wr_region) begin
                user_mem[user_wr_idx] <= wr_dat;
            end else begin
                boot_mem[wr_line] <= wr_dat;
            end
        end
    end

    // The empty-line source never touches either RAM.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            rd_dat <= 1'b0;
        end else if (rd_en) begin
            case (rd_sel)
                RSEL_BOOT: rd_dat <= boot_mem[rd_line];
                RSEL_USER: rd_dat <= user_mem[user_rd_idx];
                default:   rd_dat <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/bubble_page_buffer.sv
// NCH-channel bubble output buffer with boot region, empty-line path and double-banked user pages.
// DOUT valid one MCLK after a read-enable edge; writes always accepted; swap waits for a non-USER edge.
module bubble_page_buffer
    import bubble_page_buffer_pkg::*;
#(
    parameter int                       NCH          = 4,
    parameter int                       BOOT_AW      = 13,
    parameter int                       PAGE_AW      = 10,
    parameter int                       CH_AW        = 2,
    parameter logic [2**BOOT_AW-1:0]    D0_BOOT_INIT = '0
) (
    input  logic                        MCLK,
    input  logic                        RESET,
    input  logic [1:0]                  CHMODE,
    input  logic [2:0]                  ACCTYPE,
    input  logic [BOOT_AW-1:0]          BOUTCYCLENUM,
    input  logic                        nBOUTCLKEN,
    input  logic                        nOUTBUFWRCLKEN,
    input  logic                        OUTBUFWRREGION,
    input  logic [BOOT_AW+CH_AW-1:0]    OUTBUFWRADDR,
    input  logic                        OUTBUFWRDATA,
    input  logic                        PAGECOMMIT,
    output logic                        FRONTBANK,
    output logic                        SWAPPENDING,
    output logic [NCH-1:0]              DOUT
);

    chmode_e            chmode;
    logic [2:0]         act_cnt;
    logic [BOOT_AW+1:0] wr_addr_ext;
    logic [1:0]         wr_ch;
    logic [BOOT_AW-1:0] wr_line;
    logic               wr_en;
    logic               rd_en;
    rd_sel_e            rd_sel;
    swap_state_e        state;
    swap_state_e        state_nxt;
    logic               front_bank;
    logic               front_bank_nxt;
    logic [NCH-1:0]     rd_reg;

    assign chmode  = chmode_e'(CHMODE);
    assign act_cnt = active_count(chmode);
    assign wr_en   = ~nOUTBUFWRCLKEN;
    assign rd_en   = ~nBOUTCLKEN;
    assign rd_sel  = decode_acctype(ACCTYPE);

    // Widened so the 4-channel slice stays in range for narrow CH_AW builds.
    assign wr_addr_ext = (BOOT_AW+2)'(OUTBUFWRADDR);

    always_comb begin
        wr_ch   = 2'd0;
        wr_line = '0;
        case (chmode)
            CHM_1: begin
                wr_ch   = 2'd0;
                wr_line = wr_addr_ext[BOOT_AW-1:0];
            end
            CHM_4: begin
                wr_ch   = wr_addr_ext[1:0];
                wr_line = wr_addr_ext[BOOT_AW+1:2];
            end
            default: begin
                wr_ch   = {1'b0, wr_addr_ext[0]};
                wr_line = wr_addr_ext[BOOT_AW:1];
            end
        endcase
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            front_bank <= 1'b0;
        end else begin
            state      <= state_nxt;
            front_bank <= front_bank_nxt;
        end
    end

    // A pending swap is held off while the front page is being streamed.
    always_comb begin
        state_nxt      = state;
        front_bank_nxt = front_bank;
        case (state)
            IDLE: begin
                if (PAGECOMMIT) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (ACCTYPE != ACC_USER) begin
                    state_nxt      = IDLE;
                    front_bank_nxt = ~front_bank;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign FRONTBANK   = front_bank;
    assign SWAPPENDING = (state == PEND);

    // Channel indices beyond NCH match no instance, so such writes are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic ch_wr_en;

        assign ch_wr_en = wr_en && (wr_ch == 2'(i));

        bubble_channel_ram #(
            .BOOT_AW   (BOOT_AW),
            .PAGE_AW   (PAGE_AW),
            .BOOT_INIT ((i == 0) ? D0_BOOT_INIT : '0)
        ) u_ram (
            .MCLK      (MCLK),
            .RESET     (RESET),
            .wr_en     (ch_wr_en),
            .wr_region (OUTBUFWRREGION),
            .wr_line   (wr_line),
            .wr_bank   (~front_bank),
            .wr_dat    (OUTBUFWRDATA),
            .rd_en     (rd_en),
            .rd_sel    (rd_sel),
            .rd_line   (BOUTCYCLENUM),
            .rd_bank   (front_bank),
            .rd_dat    (rd_reg[i])
        );

        assign DOUT[i] = (3'(i) < act_cnt) ? ~rd_reg[i] : 1'b0;
    end

endmodule

// File: tb/tb_bubble_page_buffer.sv
// Directed plus randomized checks of bubble_page_buffer against a line/bank array model.
module tb_bubble_page_buffer;

    logic        MCLK = 1'b0;
    logic        RESET = 1'b1;
    logic [1:0]  CHMODE;
    logic [2:0]  ACCTYPE;
    logic [12:0] BOUTCYCLENUM;
    logic        nBOUTCLKEN;
    logic        nOUTBUFWRCLKEN;
    logic        OUTBUFWRREGION;
    logic [14:0] OUTBUFWRADDR;
    logic        OUTBUFWRDATA;
    logic        PAGECOMMIT;
    logic        FRONTBANK;
    logic        SWAPPENDING;
    logic [3:0]  DOUT;

    bubble_page_buffer #(
        .NCH     (4),
        .BOOT_AW (13),
        .PAGE_AW (10),
        .CH_AW   (2)
    ) dut (
        .MCLK           (MCLK),
        .RESET          (RESET),
        .CHMODE         (CHMODE),
        .ACCTYPE        (ACCTYPE),
        .BOUTCYCLENUM   (BOUTCYCLENUM),
        .nBOUTCLKEN     (nBOUTCLKEN),
        .nOUTBUFWRCLKEN (nOUTBUFWRCLKEN),
        .OUTBUFWRREGION (OUTBUFWRREGION),
        .OUTBUFWRADDR   (OUTBUFWRADDR),
        .OUTBUFWRDATA   (OUTBUFWRDATA),
        .PAGECOMMIT     (PAGECOMMIT),
        .FRONTBANK      (FRONTBANK),
        .SWAPPENDING    (SWAPPENDING),
        .DOUT           (DOUT)
    );

    always #10 MCLK = ~MCLK;

    // Reference model: per-channel line arrays plus "known" flags for never-written cells.
    bit bm [4][8192];
    bit bk [4][8192];
    bit um [4][2048];
    bit uk [4][2048];
    bit rr [4];
    bit rk [4];
    bit mfront;
    bit mpend;
    int total = 0;
    int bad   = 0;

    function automatic int n_active(input logic [1:0] m);
        case (m)
            2'b00:   return 1;
            2'b10:   return 4;
            default: return 2;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            rr[c] = 1'b0;
            rk[c] = 1'b1;
        end
        mfront = 1'b0;
        mpend  = 1'b0;
    endtask

    task automatic model_edge();
        int n;
        int ch;
        int line;
        int ui;
        n = n_active(CHMODE);
        if (!nBOUTCLKEN) begin
            for (int c = 0; c < 4; c++) begin
                if (ACCTYPE == 3'b110) begin
                    rr[c] = bm[c][BOUTCYCLENUM];
                    rk[c] = bk[c][BOUTCYCLENUM];
                end else if (ACCTYPE == 3'b111) begin
                    ui = (mfront ? 1024 : 0) + int'(BOUTCYCLENUM) % 1024;
                    rr[c] = um[c][ui];
                    rk[c] = uk[c][ui];
                end else begin
                    rr[c] = 1'b0;
                    rk[c] = 1'b1;
                end
            end
        end
        if (!nOUTBUFWRCLKEN) begin
            ch   = int'(OUTBUFWRADDR) % n;
            line = (int'(OUTBUFWRADDR) / n) % 8192;
            if (OUTBUFWRREGION) begin
                ui = (mfront ? 0 : 1024) + line % 1024;
                um[ch][ui] = OUTBUFWRDATA;
                uk[ch][ui] = 1'b1;
            end else begin
                bm[ch][line] = OUTBUFWRDATA;
                bk[ch][line] = 1'b1;
            end
        end
        if (mpend) begin
            if (ACCTYPE != 3'b111) begin
                mpend  = 1'b0;
                mfront = !mfront;
            end
        end else if (PAGECOMMIT) begin
            mpend = 1'b1;
        end
    endtask

    // Called at a falling edge; applies the model for the coming rising edge.
    task automatic step();
        if (RESET) model_reset();
        else       model_edge();
        @(posedge MCLK);
        @(negedge MCLK);
    endtask

    task automatic idle();
        nBOUTCLKEN     = 1'b1;
        nOUTBUFWRCLKEN = 1'b1;
        OUTBUFWRREGION = 1'b0;
        OUTBUFWRADDR   = '0;
        OUTBUFWRDATA   = 1'b0;
        PAGECOMMIT     = 1'b0;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_dout(input string tag);
        logic [3:0] exp;
        logic [3:0] mask;
        int n;
        n = n_active(CHMODE);
        for (int c = 0; c < 4; c++) begin
            if (c < n) begin
                exp[c]  = !rr[c];
                mask[c] = rk[c];
            end else begin
                exp[c]  = 1'b0;
                mask[c] = 1'b1;
            end
        end
        if (mask != 4'b0000) check(tag, DOUT & mask, exp & mask);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_front"}, 4'(FRONTBANK), 4'(mfront));
        check({tag, "_pend"}, 4'(SWAPPENDING), 4'(mpend));
    endtask

    task automatic boot_write(input int addr, input logic d);
        nOUTBUFWRCLKEN = 1'b0;
        OUTBUFWRREGION = 1'b0;
        OUTBUFWRADDR   = 15'(addr);
        OUTBUFWRDATA   = d;
        step();
        idle();
    endtask

    task automatic read_line(input logic [2:0] acc, input int line);
        ACCTYPE      = acc;
        BOUTCYCLENUM = 13'(line);
        nBOUTCLKEN   = 1'b0;
        step();
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int line;
        CHMODE       = 2'b01;
        ACCTYPE      = 3'b000;
        BOUTCYCLENUM = '0;
        idle();
        model_reset();
        for (int l = 0; l < 8192; l++) bk[0][l] = 1'b1;
        repeat (3) @(negedge MCLK);

        check("reset_dout", DOUT, 4'b0011);
        check_state("reset");
        RESET = 1'b0;

        // Mode 2 boot write to channel 1 line 5, then read it back.
        ACCTYPE = 3'b110;
        boot_write(2*5+1, 1'b1);
        read_line(3'b110, 5);
        check("m2_boot_read", DOUT, 4'b0001);
        check_dout("m2_boot_read_model");
        step();
        check_dout("m2_boot_hold");

        // Mode 4 fill of back bank 1, then commit while streaming.
        CHMODE  = 2'b10;
        ACCTYPE = 3'b111;
        for (int l = 0; l < 584; l++) begin
            for (int c = 0; c < 4; c++) begin
                nOUTBUFWRCLKEN = 1'b0;
                OUTBUFWRREGION = 1'b1;
                OUTBUFWRADDR   = 15'(l*4 + c);
                OUTBUFWRDATA   = l[0];
                step();
            end
        end
        idle();
        PAGECOMMIT = 1'b1;
        step();
        idle();
        check("commit_pend", 4'(SWAPPENDING), 4'b0001);
        check_state("commit");
        for (int k = 0; k < 100; k++) begin
            read_line(3'b111, int'($urandom_range(0, 583)));
            check("stream_front_held", 4'(FRONTBANK), 4'b0000);
            check_dout("stream_read");
        end
        check("stream_still_pend", 4'(SWAPPENDING), 4'b0001);
        ACCTYPE = 3'b000;
        step();
        check("swap_front", 4'(FRONTBANK), 4'b0001);
        check_state("swap");
        read_line(3'b111, 3);
        check("user_line3", DOUT, 4'b0000);
        read_line(3'b111, 4);
        check("user_line4", DOUT, 4'b1111);
        read_line(3'b111, 1024 + 3);
        check("user_line3_hibits", DOUT, 4'b0000);
        check_dout("user_line3_hibits_model");

        // Second commit while pending must give a single toggle.
        ACCTYPE    = 3'b111;
        PAGECOMMIT = 1'b1;
        step();
        step();
        PAGECOMMIT = 1'b0;
        step();
        check("dbl_commit_pend", 4'(SWAPPENDING), 4'b0001);
        ACCTYPE = 3'b000;
        step();
        step();
        step();
        check("dbl_commit_front", 4'(FRONTBANK), 4'b0000);
        check_state("dbl_commit");

        // Empty-line reads after a boot read that loaded ones.
        for (int k = 0; k < 3; k++) begin
            read_line(3'b110, 5);
            check_dout("pre_empty_boot");
            read_line(3'b000, k);
            check("empty_read", DOUT, 4'b1111);
        end

        // Async reset in the middle of a pending swap.
        ACCTYPE    = 3'b000;
        PAGECOMMIT = 1'b1;
        step();
        PAGECOMMIT = 1'b0;
        step();
        ACCTYPE      = 3'b111;
        PAGECOMMIT   = 1'b1;
        nBOUTCLKEN   = 1'b0;
        BOUTCYCLENUM = 13'd3;
        step();
        idle();
        check("pre_rst_front", 4'(FRONTBANK), 4'b0001);
        check("pre_rst_pend", 4'(SWAPPENDING), 4'b0001);
        check("pre_rst_dout", DOUT, 4'b0000);
        #3 RESET = 1'b1;
        #1;
        model_reset();
        check("rst_pend", 4'(SWAPPENDING), 4'b0000);
        check("rst_front", 4'(FRONTBANK), 4'b0000);
        check("rst_dout", DOUT, 4'b1111);
        @(negedge MCLK);
        RESET      = 1'b0;
        ACCTYPE    = 3'b000;
        PAGECOMMIT = 1'b1;
        step();
        PAGECOMMIT = 1'b0;
        step();
        read_line(3'b111, 5);
        check("bank_kept_after_rst", DOUT, 4'b0000);
        check_state("after_rst");

        // Mode 1 ignores the channel field: lands on channel 0 only.
        ACCTYPE = 3'b000;
        CHMODE  = 2'b10;
        for (int c = 0; c < 4; c++) boot_write(40*4 + c, 1'b0);
        CHMODE = 2'b00;
        boot_write(32'h6028, 1'b1);
        CHMODE = 2'b10;
        read_line(3'b110, 40);
        check("mode1_ch0_only", DOUT, 4'b1110);
        check_dout("mode1_model");

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            if (k % 60 == 0) CHMODE = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       ACCTYPE = 3'b000;
                1:       ACCTYPE = 3'b110;
                default: ACCTYPE = 3'b111;
            endcase
            BOUTCYCLENUM   = 13'($urandom_range(0, 15) + ($urandom_range(0, 1) == 1 ? 1024 * $urandom_range(0, 6) : 0));
            nBOUTCLKEN     = 1'($urandom_range(0, 1));
            nOUTBUFWRCLKEN = 1'($urandom_range(0, 1));
            OUTBUFWRREGION = 1'($urandom_range(0, 1));
            OUTBUFWRDATA   = 1'($urandom_range(0, 1));
            line = int'($urandom_range(0, 15)) + (OUTBUFWRREGION ? 1024 * int'($urandom_range(0, 6)) : 0);
            n = n_active(CHMODE);
            OUTBUFWRADDR   = 15'(line * n + int'($urandom_range(0, n - 1)));
            PAGECOMMIT     = ($urandom_range(0, 15) == 0);
            step();
            check_dout("rand_dout");
            check_state("rand");
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
